// File: rtl/ahb_wb_slave_decoder_if.sv
// Bus bundle for the Wishbone slave decoder.
// Holds the upstream master request/response and the shared downstream slave bus.
// Handshake: the upstream request is live while WBs_CYC_i & WBs_STB_i are high
// and completes on a one-cycle WBs_ACK_o pulse. Downstream, a slave owns the bus
// while its WBm_CYC_o bit and WBm_STB_o are high and completes with its WBm_ACK_i bit.
interface ahb_wb_slave_decoder_if #(
    parameter int ADDRWIDTH     = 17,
    parameter int DATAWIDTH     = 32,
    parameter int SLV_ADDRWIDTH = 10
);
    // Upstream (master-facing) request and response
    logic [ADDRWIDTH-1:0]     WBs_ADR_i;
    logic                     WBs_CYC_i;
    logic                     WBs_STB_i;
    logic                     WBs_WE_i;
    logic [3:0]               WBs_BYTE_STB_i;
    logic [DATAWIDTH-1:0]     WBs_DAT_i;
    logic [DATAWIDTH-1:0]     WBs_DAT_o;
    logic                     WBs_ACK_o;

    // Downstream shared slave bus
    logic [SLV_ADDRWIDTH-1:0] WBm_ADR_o;
    logic                     WBm_WE_o;
    logic                     WBm_STB_o;
    logic [3:0]               WBm_BYTE_STB_o;
    logic [DATAWIDTH-1:0]     WBm_DAT_o;
    logic [2:0]               WBm_CYC_o;
    logic [2:0]               WBm_ACK_i;
    logic [DATAWIDTH-1:0]     WBm_DAT0_i;
    logic [DATAWIDTH-1:0]     WBm_DAT1_i;
    logic [DATAWIDTH-1:0]     WBm_DAT2_i;

    // Decoder view
    modport slave (
        input  WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i, WBs_DAT_i,
        output WBs_DAT_o, WBs_ACK_o,
        output WBm_ADR_o, WBm_WE_o, WBm_STB_o, WBm_BYTE_STB_o, WBm_DAT_o, WBm_CYC_o,
        input  WBm_ACK_i, WBm_DAT0_i, WBm_DAT1_i, WBm_DAT2_i
    );

    // Environment view (upstream master plus downstream slaves)
    modport master (
        output WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i, WBs_DAT_i,
        input  WBs_DAT_o, WBs_ACK_o,
        input  WBm_ADR_o, WBm_WE_o, WBm_STB_o, WBm_BYTE_STB_o, WBm_DAT_o, WBm_CYC_o,
        output WBm_ACK_i, WBm_DAT0_i, WBm_DAT1_i, WBm_DAT2_i
    );
endinterface

// File: rtl/ahb_wb_slave_decoder.sv
// Wishbone address decoder: routes one upstream request to one of three slaves
// by address region, answers unmapped regions with a default value, guards each
// slave access with a timeout, and records bus errors (sticky flag, count, address).
module ahb_wb_slave_decoder #(
    parameter int          ADDRWIDTH      = 17,
    parameter int          DATAWIDTH      = 32,
    parameter int          SLV_ADDRWIDTH  = 10,
    parameter int          SLV0_REGION    = 0,
    parameter int          SLV1_REGION    = 1,
    parameter int          SLV2_REGION    = 2,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255,
    parameter logic [31:0] DEF_REG_VALUE  = 32'hFABDEFAC,
    parameter logic [31:0] TIMEOUT_VALUE  = 32'hDEADDEAD
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_n_i,
    ahb_wb_slave_decoder_if.slave bus,
    input  logic                 clr_err_i,
    output logic                 bus_err_o,
    output logic [7:0]           err_cnt_o,
    output logic [ADDRWIDTH-1:0] err_adr_o,
    output logic [1:0]           state_o
);

    localparam int                   RW       = ADDRWIDTH - SLV_ADDRWIDTH;
    localparam logic [RW-1:0]        R0       = RW'(SLV0_REGION);
    localparam logic [RW-1:0]        R1       = RW'(SLV1_REGION);
    localparam logic [RW-1:0]        R2       = RW'(SLV2_REGION);
    localparam logic [7:0]           TO_LAST  = TIMEOUT_CYCLES - 8'd1;
    localparam logic [DATAWIDTH-1:0] DEF_DAT  = DATAWIDTH'(DEF_REG_VALUE);
    localparam logic [DATAWIDTH-1:0] TO_DAT   = DATAWIDTH'(TIMEOUT_VALUE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    // Latched request
    logic [2:0]             sel_r;
    logic [ADDRWIDTH-1:0]   req_adr;
    logic                   req_we;
    logic [3:0]             req_bs;
    logic [DATAWIDTH-1:0]   req_dat;
    logic [7:0]             to_cnt;

    // Decode and FSM control strobes
    logic [RW-1:0]          region;
    logic [2:0]             sel_dec;
    logic                   ack_hit;
    logic [DATAWIDTH-1:0]   slv_dat;
    logic                   acc_map;
    logic                   acc_unmap;
    logic                   done_ack;
    logic                   done_to;
    logic                   cnt_inc;
    logic                   err_set;
    logic [ADDRWIDTH-1:0]   err_adr_nxt;

    assign region  = bus.WBs_ADR_i[ADDRWIDTH-1:SLV_ADDRWIDTH];
    assign ack_hit = |(bus.WBm_ACK_i & sel_r);

    // One-hot slave select from the incoming address region
    always_comb begin
        sel_dec    = 3'b000;
        sel_dec[0] = (region == R0);
        sel_dec[1] = (region == R1);
        sel_dec[2] = (region == R2);
    end

    // Read data of the currently selected slave
    always_comb begin
        slv_dat = bus.WBm_DAT0_i;
        if (sel_r[1]) begin
            slv_dat = bus.WBm_DAT1_i;
        end else if (sel_r[2]) begin
            slv_dat = bus.WBm_DAT2_i;
        end
    end

    // State register
    always_ff @(posedge WBs_CLK_i) begin
        if (!WBs_RST_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and control strobes; a selected ACK beats the timeout in the expiry cycle
    always_comb begin
        state_nxt = state;
        acc_map   = 1'b0;
        acc_unmap = 1'b0;
        done_ack  = 1'b0;
        done_to   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.WBs_CYC_i && bus.WBs_STB_i) begin
                    if (|sel_dec) begin
                        acc_map   = 1'b1;
                        state_nxt = BUSY;
                    end else begin
                        acc_unmap = 1'b1;
                        state_nxt = ACK;
                    end
                end
            end
            BUSY: begin
                if (!bus.WBs_CYC_i) begin
                    state_nxt = IDLE;
                end else if (ack_hit) begin
                    done_ack  = 1'b1;
                    state_nxt = ACK;
                end else if (to_cnt == TO_LAST) begin
                    done_to   = 1'b1;
                    state_nxt = ACK;
                end else begin
                    cnt_inc   = 1'b1;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch, timeout counter and upstream read data
    always_ff @(posedge WBs_CLK_i) begin
        if (!WBs_RST_n_i) begin
            sel_r         <= 3'b000;
            req_adr       <= '0;
            req_we        <= 1'b0;
            req_bs        <= 4'b0000;
            req_dat       <= '0;
            to_cnt        <= 8'd0;
            bus.WBs_DAT_o <= '0;
        end else begin
            if (acc_map) begin
                sel_r   <= sel_dec;
                req_adr <= bus.WBs_ADR_i;
                req_we  <= bus.WBs_WE_i;
                req_bs  <= bus.WBs_BYTE_STB_i;
                req_dat <= bus.WBs_DAT_i;
                to_cnt  <= 8'd0;
            end else if (cnt_inc) begin
                to_cnt  <= to_cnt + 8'd1;
            end
            if (acc_unmap) begin
                bus.WBs_DAT_o <= DEF_DAT;
            end else if (done_ack) begin
                bus.WBs_DAT_o <= slv_dat;
            end else if (done_to) begin
                bus.WBs_DAT_o <= TO_DAT;
            end
        end
    end

    assign err_set     = acc_unmap | done_to;
    assign err_adr_nxt = acc_unmap ? bus.WBs_ADR_i : req_adr;

    // Error recording; a new error in the same cycle as a clear leaves flag set and count 1
    always_ff @(posedge WBs_CLK_i) begin
        if (!WBs_RST_n_i) begin
            bus_err_o <= 1'b0;
            err_cnt_o <= 8'd0;
            err_adr_o <= '0;
        end else if (err_set) begin
            bus_err_o <= 1'b1;
            err_adr_o <= err_adr_nxt;
            if (clr_err_i) begin
                err_cnt_o <= 8'd1;
            end else if (err_cnt_o != 8'hFF) begin
                err_cnt_o <= err_cnt_o + 8'd1;
            end
        end else if (clr_err_i) begin
            bus_err_o <= 1'b0;
            err_cnt_o <= 8'd0;
        end
    end

    // Downstream bus is live only in BUSY; address/data come from the request latch
    assign bus.WBm_CYC_o      = (state == BUSY) ? sel_r : 3'b000;
    assign bus.WBm_STB_o      = (state == BUSY);
    assign bus.WBm_ADR_o      = req_adr[SLV_ADDRWIDTH-1:0];
    assign bus.WBm_WE_o       = req_we;
    assign bus.WBm_BYTE_STB_o = req_bs;
    assign bus.WBm_DAT_o      = req_dat;
    assign bus.WBs_ACK_o      = (state == ACK);
    assign state_o            = state;

endmodule

// File: doc/ahb_wb_slave_decoder.md
AHB_WB_SLAVE_DECODER -- requirements
Module: ahb_wb_slave_decoder

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 17; width of the master-side Wishbone byte address.
REQ-002 SHALL have parameter DATAWIDTH, default 32; data bus width.
REQ-003 SHALL have parameter SLV_ADDRWIDTH, default 10; slave-side address width; region select = WBs_ADR_i[ADDRWIDTH-1:SLV_ADDRWIDTH].
REQ-004 SHALL have parameters SLV0_REGION, SLV1_REGION, SLV2_REGION, defaults 0, 1, 2; region select codes of slaves 0..2.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 8'd255; maximum wait for a slave ACK.
REQ-006 SHALL have parameters DEF_REG_VALUE (32'hFABDEFAC, unmapped read data) and TIMEOUT_VALUE (32'hDEADDEAD, timeout read data).
REQ-007 Ports: WBs_CLK_i in 1, sole clock; WBs_RST_n_i in 1, reset (single clock domain; reset synchronous, active-low).
REQ-008 Ports: WBs_ADR_i in ADDRWIDTH; WBs_CYC_i in 1; WBs_STB_i in 1; WBs_WE_i in 1; WBs_BYTE_STB_i in 4; WBs_DAT_i in DATAWIDTH (master request).
REQ-009 Ports: WBs_DAT_o out DATAWIDTH, read data; WBs_ACK_o out 1, acknowledge to master.
REQ-010 Ports: WBm_ADR_o out SLV_ADDRWIDTH; WBm_WE_o out 1; WBm_STB_o out 1; WBm_BYTE_STB_o out 4; WBm_DAT_o out DATAWIDTH (shared slave-side bus).
REQ-011 Ports: WBm_CYC_o out 3, per-slave cycle select; WBm_ACK_i in 3, per-slave ACK; WBm_DAT0_i, WBm_DAT1_i, WBm_DAT2_i in DATAWIDTH each, slave read data.
REQ-012 Ports: clr_err_i in 1; bus_err_o out 1, sticky error; err_cnt_o out 8, error count; err_adr_o out ADDRWIDTH, address of last error.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, ACK.
REQ-014 IDLE: on CYC_i&STB_i with a mapped region -> latch one-hot select into sel_r, latch address/WE/BYTE_STB/DAT into the request register, clear timeout counter, go to BUSY.
REQ-015 IDLE: on CYC_i&STB_i with an unmapped region -> go to ACK with DAT_o=DEF_REG_VALUE; no WBm_CYC_o asserted; counts as error.
REQ-016 BUSY: WBm_CYC_o=sel_r, WBm_STB_o=1; slave-side buses driven from the request register (WBm_ADR_o = latched ADR[SLV_ADDRWIDTH-1:0]).
REQ-017 BUSY: selected WBm_ACK_i=1 -> register that slave's DAT into WBs_DAT_o, go to ACK; ACK_i from unselected slaves ignored.
REQ-018 BUSY: counter increments each cycle; when counter == TIMEOUT_CYCLES-1 and no selected ACK -> drop WBm_CYC_o, go to ACK with DAT_o=TIMEOUT_VALUE; counts as error.
REQ-019 Selected ACK arriving in the expiry cycle SHALL win; no error recorded.
REQ-020 ACK: WBs_ACK_o=1 for exactly one cycle, WBm_CYC_o=0, WBm_STB_o=0; next state IDLE unconditionally.
REQ-021 Master CYC_i deasserted in BUSY -> abort: WBm_CYC_o=0 next cycle, go to IDLE, no WBs_ACK_o, no error.
REQ-022 Latency, zero-wait slave acking one cycle after its CYC: request sampled edge E0, slave CYC high after E0, slave ACK after E1, WBs_ACK_o high after E2 (3 cycles).
REQ-023 WBs_DAT_o SHALL hold its last value outside ACK state.
REQ-024 On each error: bus_err_o<=1, err_adr_o<=latched address, err_cnt_o increments saturating at 8'hFF.
REQ-025 clr_err_i=1 clears bus_err_o and err_cnt_o; error in the same cycle wins (flag=1, count=1).
REQ-026 Writes and reads use identical flow; WE only forwarded.

Reset
REQ-027 WBs_RST_n_i low at a WBs_CLK_i edge SHALL force state IDLE, WBs_ACK_o=0, WBs_DAT_o=0, WBm_CYC_o=0, WBm_STB_o=0, WBm_ADR_o=0, WBm_WE_o=0, WBm_BYTE_STB_o=0, WBm_DAT_o=0, bus_err_o=0, err_cnt_o=0, err_adr_o=0, counter=0.
REQ-028 Reset mid-transaction SHALL drop all CYC/ACK at that edge, with no later ACK for the aborted request.

Verification
REQ-029 Read region 0 addr offset 0x004, slave0 acks one cycle after CYC with 32'h00000100 -> WBs_ACK_o pulse 3 cycles after request, DAT_o=32'h00000100, WBm_CYC_o=3'b001.
REQ-030 Write region 2, slave2 acks -> WBm_CYC_o=3'b100, WBm_WE_o=1, WBm_DAT_o matches master data, single ACK, no error.
REQ-031 Read region 5 (unmapped) -> ACK with DAT_o=32'hFABDEFAC, WBm_CYC_o stays 0, bus_err_o=1, err_cnt_o=1, err_adr_o=request address.
REQ-032 Slave 1 never acks, TIMEOUT_CYCLES=4 -> ACK with 32'hDEADDEAD, bus_err_o=1; ACK at expiry cycle -> slave data, no error.
REQ-033 Drop CYC_i in BUSY; assert reset in BUSY; clr_err_i with simultaneous error; 256 errors -> abort/reset give no ACK, clear-vs-set yields count 1, counter saturates at 8'hFF.
